// File: rtl/tick_counter_pkg.sv
// Shared constants for the tick_counter timebase divider.
// Holds the default datapath width used by the counter and its bus interface.
package tick_counter_pkg;

  // Default width of the modulus input and count output.
  localparam int unsigned TC_WIDTH = 16;

endpackage : tick_counter_pkg

// File: rtl/tick_counter_if.sv
// Bus between a tick_counter and its consumer.
// Carries the modulus, the running count and the terminal-count tick.
interface tick_counter_if
  import tick_counter_pkg::*;
#(
  parameter int unsigned WIDTH = TC_WIDTH
) ();

  logic [WIDTH-1:0] times;
  logic [WIDTH-1:0] cnt;
  logic             c;

  // The consumer supplies the period and reads back the count and tick.
  modport master (
    output times,
    input  cnt,
    input  c
  );

  modport slave (
    input  times,
    output cnt,
    output c
  );

endinterface : tick_counter_if

// File: rtl/tick_counter.sv
// Free-running modulo-N cycle counter with a registered one-cycle tick.
// The period N is read from the bus every cycle, so it may change at run time.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int unsigned WIDTH = TC_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  tick_counter_if.slave  bus
);

  // NOTE: declaration initialisers give the power-up value; users may tie
  // reset low, so the registers must start at zero without it.
  logic [WIDTH-1:0] cnt_q = '0;
  logic             c_q   = 1'b0;
  logic [WIDTH-1:0] cnt_d;
  logic             c_d;
  logic             at_terminal;

  // cnt + 1 >= times is cnt >= times - 1 without the subtraction; the extra
  // bit keeps cnt = all-ones from wrapping and makes times = 0 always wrap.
  assign at_terminal = ({1'b0, cnt_q} + (WIDTH + 1)'(1)) >= {1'b0, bus.times};

  // NOTE: every combinational output gets its default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    c_d   = 1'b0;
    if (at_terminal) begin
      cnt_d = '0;
      c_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      c_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      c_q   <= c_d;
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.c   = c_q;

endmodule : tick_counter

// File: tb/tb_tick_counter.sv
// Directed self-checking bench for tick_counter.
// Expected values are hand-derived from the modulo-N counting rules.
module tb_tick_counter;
  import tick_counter_pkg::*;

  localparam int unsigned W = TC_WIDTH;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  tick_counter_if #(.WIDTH(W)) bus ();

  tick_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cnt_exp5 [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
    int c_exp5   [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int ticks;
    int first_tick;
    int last_tick;
    int spacing_bad;
    int max_cnt;
    int found;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.times   = 16'd4;

    // Power-up with reset never asserted, times = 4.
    #1;
    check("powerup_cnt", 32'(bus.cnt), 32'd0);
    check("powerup_c",   32'(bus.c),   32'd0);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("pu_cnt_e%0d", e), 32'(bus.cnt), 32'(e % 4));
      check($sformatf("pu_c_e%0d", e),   32'(bus.c),   32'((e % 4) == 0));
    end

    // Reset, then times = 5 for 12 edges.
    bus.times = 16'd5;
    do_reset();
    check("rst_cnt", 32'(bus.cnt), 32'd0);
    check("rst_c",   32'(bus.c),   32'd0);
    for (int e = 0; e < 12; e++) begin
      tick();
      check($sformatf("t5_cnt_e%0d", e + 1), 32'(bus.cnt), 32'(cnt_exp5[e]));
      check($sformatf("t5_c_e%0d", e + 1),   32'(bus.c),   32'(c_exp5[e]));
    end

    // Mid-count reset with times = 10.
    bus.times = 16'd10;
    do_reset();
    repeat (3) tick();
    check("mid_pre_cnt", 32'(bus.cnt), 32'd3);
    do_reset();
    check("mid_rst_cnt", 32'(bus.cnt), 32'd0);
    check("mid_rst_c",   32'(bus.c),   32'd0);
    found = 0;
    for (int e = 1; e <= 20 && found == 0; e++) begin
      tick();
      if (bus.c === 1'b1) found = e;
    end
    check("mid_first_tick_edge", 32'(found), 32'd10);

    // Shrink times from 100 to 20 while cnt = 60.
    bus.times = 16'd100;
    do_reset();
    repeat (60) tick();
    check("shrink_pre_cnt", 32'(bus.cnt), 32'd60);
    bus.times = 16'd20;
    tick();
    check("shrink_wrap_cnt", 32'(bus.cnt), 32'd0);
    check("shrink_wrap_c",   32'(bus.c),   32'd1);
    repeat (19) tick();
    check("shrink_p19_cnt", 32'(bus.cnt), 32'd19);
    check("shrink_p19_c",   32'(bus.c),   32'd0);
    tick();
    check("shrink_p20_cnt", 32'(bus.cnt), 32'd0);
    check("shrink_p20_c",   32'(bus.c),   32'd1);

    // times = 1 then times = 0: tick every cycle, count held at zero.
    bus.times = 16'd1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("t1_cnt_e%0d", e), 32'(bus.cnt), 32'd0);
      check($sformatf("t1_c_e%0d", e),   32'(bus.c),   32'd1);
    end
    bus.times = 16'd0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("t0_cnt_e%0d", e), 32'(bus.cnt), 32'd0);
      check($sformatf("t0_c_e%0d", e),   32'(bus.c),   32'd1);
    end

    // Long period: times = 5000 over 15000 edges.
    bus.times   = 16'd5000;
    do_reset();
    ticks       = 0;
    first_tick  = 0;
    last_tick   = 0;
    spacing_bad = 0;
    max_cnt     = 0;
    for (int e = 1; e <= 15000; e++) begin
      tick();
      if (int'(bus.cnt) > max_cnt) max_cnt = int'(bus.cnt);
      if (bus.c === 1'b1) begin
        ticks++;
        if (ticks == 1) first_tick = e;
        else if (e - last_tick != 5000) spacing_bad++;
        last_tick = e;
      end
    end
    check("long_ticks",       32'(ticks),       32'd3);
    check("long_first_tick",  32'(first_tick),  32'd5000);
    check("long_spacing_bad", 32'(spacing_bad), 32'd0);
    check("long_max_cnt",     32'(max_cnt),     32'd4999);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tick_counter
